// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared RV32M mul/div types, width constant and op decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    // Encodings equal the RV32M funct3 field so op_i can be cast directly.
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_negate
// Purpose  : Conditional two's-complement negation, width parameterised.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_negate ? (~i_value + 1'b1) : i_value;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit on one shift/add-sub datapath.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $fatal(1, "muldiv_unit supports XLEN=32 only");
        end
    endgenerate

    localparam int                c_cnt_w = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(XLEN - 1);

    muldiv_state_e         r_state;
    muldiv_state_e         w_state_next;
    muldiv_op_e            r_op;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic                  r_b_zero;
    logic [c_cnt_w-1:0]    r_count;
    logic [XLEN-1:0]       r_a_abs;
    logic [XLEN-1:0]       r_b_abs;
    logic [2*XLEN-1:0]     r_acc;
    logic [XLEN-1:0]       r_result;

    logic                  w_accept;
    logic                  w_sign_a;
    logic                  w_sign_b;
    logic [XLEN-1:0]       w_a_abs;
    logic [XLEN-1:0]       w_b_abs;
    logic                  w_b_zero;
    logic                  w_ovf;
    logic                  w_early;
    logic [XLEN-1:0]       w_early_result;
    logic                  w_last_iter;

    logic [2*XLEN-1:0]     w_addend;
    logic [2*XLEN-1:0]     w_mul_next;
    logic [XLEN:0]         w_rem_sh;
    logic [XLEN:0]         w_trial;
    logic                  w_q_bit;
    logic [2*XLEN-1:0]     w_div_next;
    logic [2*XLEN-1:0]     w_acc_next;

    logic [2*XLEN-1:0]     w_fix_in;
    logic                  w_fix_neg;
    logic [2*XLEN-1:0]     w_fixed;
    logic [XLEN-1:0]       w_final;

    assign ready_o  = (r_state == IDLE) || (r_state == DONE);
    assign busy_o   = (r_state == CALC);
    assign done_o   = (r_state == DONE);
    assign result_o = r_result;

    assign w_accept = start_i & ready_o & ~flush_i;

    // ---------------- operand conditioning ----------------
    assign w_sign_a = is_signed_a(op_i) & a_i[XLEN-1];
    assign w_sign_b = is_signed_b(op_i) & b_i[XLEN-1];

    muldiv_negate #(.WIDTH(XLEN)) u_abs_a (
        .i_value  (a_i),
        .i_negate (w_sign_a),
        .o_value  (w_a_abs)
    );

    muldiv_negate #(.WIDTH(XLEN)) u_abs_b (
        .i_value  (b_i),
        .i_negate (w_sign_b),
        .o_value  (w_b_abs)
    );

    assign w_b_zero = (b_i == '0);
    assign w_ovf    = ((op_i == DIV) || (op_i == REM))
                      && (a_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (b_i == '1);
    assign w_early  = EARLY_OUT && is_div(op_i) && (w_b_zero || w_ovf);

    always_comb begin
        w_early_result = '0;
        if (is_rem(op_i)) begin
            w_early_result = w_b_zero ? a_i : '0;
        end else begin
            w_early_result = w_b_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // ---------------- iteration datapath ----------------
    assign w_addend   = {{XLEN{1'b0}}, r_b_abs} << r_count;
    assign w_mul_next = r_a_abs[r_count] ? (r_acc + w_addend) : r_acc;

    // Restoring divide: r_acc = {remainder, dividend shifting into quotient}.
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_trial    = w_rem_sh - {1'b0, r_b_abs};
    assign w_q_bit    = ~w_trial[XLEN];
    assign w_div_next = {(w_q_bit ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_q_bit};

    assign w_acc_next  = is_div(r_op) ? w_div_next : w_mul_next;
    assign w_last_iter = (r_state == CALC) && (r_count == c_last) && !flush_i;

    // ---------------- sign correction and selection ----------------
    // Divide-by-zero keeps the all-ones quotient unsigned-looking, so skip negation.
    always_comb begin
        w_fix_in  = w_acc_next;
        w_fix_neg = r_sign_a ^ r_sign_b;
        case (r_op)
            DIV, DIVU: begin
                w_fix_in  = {{XLEN{1'b0}}, w_acc_next[XLEN-1:0]};
                w_fix_neg = (r_sign_a ^ r_sign_b) & ~r_b_zero;
            end
            REM, REMU: begin
                w_fix_in  = {{XLEN{1'b0}}, w_acc_next[2*XLEN-1:XLEN]};
                w_fix_neg = r_sign_a;
            end
            default: begin
                w_fix_in  = w_acc_next;
                w_fix_neg = r_sign_a ^ r_sign_b;
            end
        endcase
    end

    muldiv_negate #(.WIDTH(2*XLEN)) u_fix (
        .i_value  (w_fix_in),
        .i_negate (w_fix_neg),
        .o_value  (w_fixed)
    );

    always_comb begin
        w_final = w_fixed[XLEN-1:0];
        if ((r_op == MULH) || (r_op == MULHSU) || (r_op == MULHU)) begin
            w_final = w_fixed[2*XLEN-1:XLEN];
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        w_state_next = w_early ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (r_count == c_last) begin
                        w_state_next = DONE;
                    end
                end
                DONE: begin
                    if (start_i) begin
                        w_state_next = w_early ? DONE : CALC;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // ---------------- working registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
            r_count  <= '0;
            r_a_abs  <= '0;
            r_b_abs  <= '0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_op     <= muldiv_op_e'(op_i);
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_b_zero <= w_b_zero;
            r_count  <= '0;
            r_a_abs  <= w_a_abs;
            r_b_abs  <= w_b_abs;
            r_acc    <= is_div(op_i) ? {{XLEN{1'b0}}, w_a_abs} : '0;
        end else if ((r_state == CALC) && !flush_i) begin
            r_acc    <= w_acc_next;
            r_count  <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_accept && w_early) begin
            r_result <= w_early_result;
        end else if (w_last_iter) begin
            r_result <= w_final;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Scoreboard bench for muldiv_unit (EARLY_OUT=1 and EARLY_OUT=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        start_s = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_o, busy_o, done_o;
    logic [31:0] result_o;
    logic        ready_s, busy_s, done_s;
    logic [31:0] result_s;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_sq[$];
    logic [31:0] last_result = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o)
    );

    muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) dut_slow (
        .clk(clk), .rst(rst), .start_i(start_s), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .ready_o(ready_s), .busy_o(busy_s), .done_o(done_s),
        .result_o(result_s)
    );

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ref_model = '0;
        case (op)
            3'd0: begin p = sa * sb; ref_model = p[31:0];  end
            3'd1: begin p = sa * sb; ref_model = p[63:32]; end
            3'd2: begin p = sa * ub; ref_model = p[63:32]; end
            3'd3: begin p = ua * ub; ref_model = p[63:32]; end
            3'd4: begin
                if (b == 0) ref_model = '1;
                else if (a == 32'h8000_0000 && b == '1) ref_model = 32'h8000_0000;
                else begin p = sa / sb; ref_model = p[31:0]; end
            end
            3'd5: ref_model = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) ref_model = a;
                else if (a == 32'h8000_0000 && b == '1) ref_model = '0;
                else begin p = sa % sb; ref_model = p[31:0]; end
            end
            default: ref_model = (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        if (push) exp_q.push_back(exp);
        tick();
        start_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0; busy_cnt = 0;
        while (!done_o && lat < 100) begin
            if (busy_o) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({ready_o, busy_o, done_o} !== 3'b100 || {ready_s, busy_s, done_s} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: rdy/busy/done=%b slow=%b required 100",
                     {ready_o, busy_o, done_o}, {ready_s, busy_s, done_s});
        end
        checks++;
        if (result_o !== 32'h0) begin
            errors++; $display("FAIL reset_result: result_o=%h required 0", result_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        int lat, bc;
        logic [31:0] exp;
        issue(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (done_o !== 1'b1 || lat != 32) begin
            errors++; $display("FAIL mul_latency: done_o=%b at %0d cycles required 1 at 32", done_o, lat);
        end
        checks++;
        if (bc != 32) begin
            errors++; $display("FAIL mul_busy_cycles: %0d required 32", bc);
        end
        checks++;
        if (result_o !== exp) begin
            errors++; $display("FAIL mul_result: result_o=%h required %h", result_o, exp);
        end
        last_result = exp;
        tick();
        checks++;
        if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL mul_done_pulse: done_o=%b ready_o=%b required 0 1", done_o, ready_o);
        end
    endtask

    task automatic test_high_mul();
        logic [2:0]  ops [3];
        logic [31:0] as [3];
        logic [31:0] bs [3];
        logic [31:0] es [3];
        int lat, bc;
        logic [31:0] exp;
        ops = '{3'd1, 3'd3, 3'd2};
        as  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bs  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        es  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i], es[i], 1'b1);
            wait_done(lat, bc);
            exp = exp_q.pop_front();
            checks++;
            if (done_o !== 1'b1 || result_o !== exp) begin
                errors++;
                $display("FAIL high_mul[%0d]: done_o=%b result_o=%h required 1 %h", i, done_o, result_o, exp);
            end
            last_result = exp;
            tick();
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bc;
        logic [31:0] exp;
        issue(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1);
        repeat (4) tick();
        start_i = 1'b1; op_i = DIVU; a_i = 32'd1; b_i = 32'd1;
        tick();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL busy_ignore_state: busy_o=%b required 1", busy_o);
        end
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (done_o !== 1'b1 || lat != 27 || result_o !== exp) begin
            errors++;
            $display("FAIL busy_ignore_result: done_o=%b lat=%0d result_o=%h required 1 27 %h",
                     done_o, lat, result_o, exp);
        end
        last_result = exp;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [4];
        logic [31:0] as [4];
        logic [31:0] bs [4];
        logic [31:0] es [4];
        int lat, bc;
        logic [31:0] exp;
        ops = '{3'd4, 3'd6, 3'd5, 3'd7};
        as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        bs  = '{32'd2, 32'd2, 32'd7, 32'd7};
        es  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        issue(ops[0], as[0], bs[0], es[0], 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_done(lat, bc);
            exp = exp_q.pop_front();
            checks++;
            if (done_o !== 1'b1 || lat != 32) begin
                errors++; $display("FAIL b2b_latency[%0d]: done_o=%b lat=%0d required 1 32", i, done_o, lat);
            end
            checks++;
            if (result_o !== exp) begin
                errors++; $display("FAIL b2b_result[%0d]: result_o=%h required %h", i, result_o, exp);
            end
            last_result = exp;
            if (i < 3) issue(ops[i+1], as[i+1], bs[i+1], es[i+1], 1'b1);
        end
        tick();
    endtask

    task automatic test_special_div();
        logic [2:0]  ops [3];
        logic [31:0] as [3];
        logic [31:0] bs [3];
        logic [31:0] es [3];
        int lat, bc;
        logic [31:0] exp;
        ops = '{3'd4, 3'd7, 3'd4};
        as  = '{32'd5, 32'd5, 32'h8000_0000};
        bs  = '{32'd0, 32'd0, 32'hFFFF_FFFF};
        es  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i], es[i], 1'b1);
            wait_done(lat, bc);
            exp = exp_q.pop_front();
            checks++;
            if (done_o !== 1'b1 || lat != 0 || result_o !== exp) begin
                errors++;
                $display("FAIL early_out[%0d]: done_o=%b lat=%0d result_o=%h required 1 0 %h",
                         i, done_o, lat, result_o, exp);
            end
            last_result = exp;
            tick();
        end
        // Same cases on the full-latency instance.
        for (int i = 0; i < 3; i++) begin
            int slat;
            logic [31:0] sexp;
            start_s = 1'b1; op_i = ops[i]; a_i = as[i]; b_i = bs[i];
            exp_sq.push_back(es[i]);
            tick();
            start_s = 1'b0; a_i = $urandom; b_i = $urandom;
            slat = 0;
            while (!done_s && slat < 100) begin tick(); slat++; end
            sexp = exp_sq.pop_front();
            checks++;
            if (done_s !== 1'b1 || slat != 32 || result_s !== sexp) begin
                errors++;
                $display("FAIL no_early_out[%0d]: done=%b lat=%0d result=%h required 1 32 %h",
                         i, done_s, slat, result_s, sexp);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        int lat, bc, dcount;
        logic [31:0] exp;
        issue(DIVU, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || ready_o !== 1'b1 || result_o !== last_result) begin
            errors++;
            $display("FAIL flush_kill: busy=%b done=%b ready=%b result=%h required 0 0 1 %h",
                     busy_o, done_o, ready_o, result_o, last_result);
        end
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) dcount++;
            tick();
        end
        checks++;
        if (dcount != 0) begin
            errors++; $display("FAIL flush_no_done: done pulses=%0d required 0", dcount);
        end
        start_i = 1'b1; flush_i = 1'b1; op_i = MUL; a_i = 32'd9; b_i = 32'd9;
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL flush_start_same: busy=%b done=%b required 0 0", busy_o, done_o);
        end
        issue(MUL, 32'd3, 32'd4, 32'd12, 1'b1);
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (done_o !== 1'b1 || lat != 32 || result_o !== exp) begin
            errors++;
            $display("FAIL flush_then_mul: done=%b lat=%0d result=%h required 1 32 %h",
                     done_o, lat, result_o, exp);
        end
        last_result = exp;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        logic [31:0] exp;
        issue(DIVU, 32'h0000_FFFF, 32'd3, 32'd0, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({ready_o, busy_o, done_o} !== 3'b100 || result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: rdy/busy/done=%b result=%h required 100 0",
                     {ready_o, busy_o, done_o}, result_o);
        end
        tick();
        rst = 1'b0;
        tick();
        issue(REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(lat, bc);
        exp = exp_q.pop_front();
        checks++;
        if (done_o !== 1'b1 || lat != 32 || result_o !== exp) begin
            errors++;
            $display("FAIL reset_then_rem: done=%b lat=%0d result=%h required 1 32 %h",
                     done_o, lat, result_o, exp);
        end
        last_result = exp;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pick [5];
        logic [2:0]  op;
        logic [31:0] a, b, exp;
        int lat, bc, exp_lat;
        for (int i = 0; i < 16; i++) begin
            pick = '{$urandom, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
            op = 3'($urandom);
            a  = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(1, 4)] : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(1, 4)] : $urandom;
            exp_lat = (op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) &&
                       a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 32;
            issue(op, a, b, ref_model(op, a, b), 1'b1);
            wait_done(lat, bc);
            exp = exp_q.pop_front();
            checks++;
            if (done_o !== 1'b1 || lat != exp_lat || result_o !== exp) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: done=%b lat=%0d result=%h required 1 %0d %h",
                         i, op, a, b, done_o, lat, result_o, exp_lat, exp);
            end
            last_result = exp;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_high_mul();
        test_busy_ignore();
        test_back_to_back();
        test_special_div();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, beside the integer ALU.
- Takes rs1/rs2 operands from the register-file read ports. Produces one 32-bit result for writeback.
- Multi-cycle. While busy_o is high, the pipeline control logic stalls the front end.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU using one shared shift/add-subtract datapath.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; any other value stops elaboration.
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow finish in 1 cycle instead of the full iteration.

Ports:
- clk  in  1  clock. Everything is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  request strobe. Accepted on an edge where start_i & ready_o & ~flush_i.
- op_i  in  3  operation, encoded as RV32M funct3 (000 MUL … 111 REMU). Sampled on accept.
- a_i  in  XLEN  rs1 operand. Sampled on accept.
- b_i  in  XLEN  rs2 operand. Sampled on accept.
- flush_i  in  1  kills the in-flight operation (branch mispredict or trap).
- ready_o  out  1  unit can accept. High in IDLE and DONE.
- busy_o  out  1  operation in flight. High in CALC.
- done_o  out  1  result valid. High for exactly one cycle (state DONE).
- result_o  out  XLEN  result register. Holds its value until the next DONE.

Behaviour:
- Clock and reset: one clock clk; reset rst, asynchronous, active-high.
- Reset values (while rst is high, state goes to IDLE immediately):
  - result_o=0, done_o=0, busy_o=0, ready_o=1.
  - Iteration counter=0, working registers=0.
- States: IDLE, CALC, DONE.
- IDLE, on accept:
  - Latch op, operand signs and |a|/|b| into working registers. Signed ops use absolute values; MULHSU takes the absolute value of a only.
  - Set counter=0 and go to CALC.
  - EARLY_OUT=1 with a divide op and (b==0 or (signed and a==0x80000000 and b==0xFFFFFFFF)): go straight to DONE and load result_o with the special value.
- CALC, one iteration per edge:
  - Multiply: 64-bit accumulator. Shift-add on multiplier bit [counter].
  - Divide: restoring. Shift remainder left, trial-subtract divisor, set quotient bit.
  - counter increments. After the edge with counter==31, go to DONE.
  - On that same edge, load result_o with the sign-corrected selection (rules below).
- DONE:
  - done_o=1 and ready_o=1 for one cycle.
  - Next edge: a new accept goes to CALC (back-to-back allowed); otherwise go to IDLE.
- Latency, counted from the accept edge E0:
  - Normal ops: done_o high in the cycle after edge E32, i.e. 32 cycles after accept, 33 cycles per op.
  - EARLY_OUT cases: done_o high in the cycle after E0.
- Result selection:
  - MUL = low 32 bits of the product.
  - MULH/MULHSU/MULHU = high 32 bits.
  - DIV/DIVU = quotient.
  - REM/REMU = remainder.
- Sign correction, applied to 64-bit values before selection:
  - Product is negated if sign(a)^sign(b) for MUL/MULH, or if sign(a) for MULHSU.
  - Quotient is negated if sign(a)^sign(b) for DIV.
  - Remainder takes the sign of the dividend for REM.
- Divide by zero:
  - Quotient = 0xFFFFFFFF for both DIV and DIVU.
  - Remainder = a.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- With EARLY_OUT=0, the iterative path must give these same values naturally, with full latency.
- flush_i:
  - Any state goes to IDLE on the next edge. No done_o is issued for the killed op.
  - result_o is left unchanged.
  - flush_i and start_i in the same cycle: flush wins, nothing is accepted.
- start_i while busy_o=1 is ignored. Operands are not re-sampled.
- Reset asserted mid-operation: state returns to IDLE at once and all outputs go to their reset values. No done_o is issued.
- Operands arriving while not accepting have no effect. a_i and b_i may change freely after accept.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN constant.
  - muldiv_op_e enum, values equal to RV32M funct3 (MUL=3'b000 … REMU=3'b111).
  - muldiv_state_e {IDLE, CALC, DONE}.
  - Helper functions is_div(op) and is_signed_a(op)/is_signed_b(op).
- Sub-module muldiv_negate: conditional two's-complement negate, width parameterised. It is instantiated for the operand absolute values and for the 64-bit result sign fix.
- The FSM and the iteration datapath stay in muldiv_unit.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) → result_o=0xFFFFFFEB. done_o high exactly 32 cycles after accept, for 1 cycle. busy_o high for 32 cycles.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV -7/2 → 0xFFFFFFFD and REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14 and REMU 100/7 → 2.
  - Issued back-to-back, starting in the DONE cycle, with no idle gap.
- Special divides:
  - DIV 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - With EARLY_OUT=1, done_o comes 1 cycle after accept. With EARLY_OUT=0, same values after 32 cycles.
- flush_i at cycle 10 of a DIVU → no done_o, busy_o low next cycle, result_o unchanged. start_i+flush_i in the same cycle → not accepted. A new MUL 3×4 is then accepted → 12.
- rst pulsed mid-CALC → immediately busy_o=0, done_o=0, result_o=0, ready_o=1. A following op completes correctly.
